// File: rtl/plru_repl_unit.sv
// Tree-PLRU replacement engine: per-set PLRU tree storage, victim selection with
// invalid-way priority and lock masks, and a multi-cycle flush sweep.
module plru_repl_unit #(
   parameter int unsigned N_WAY  = 16,
   parameter int unsigned N_SETS = 64,
   parameter int unsigned WAY_W  = $clog2(N_WAY),
   parameter int unsigned SET_W  = $clog2(N_SETS)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_req_valid,
   output logic             o_req_ready,
   input  logic [1:0]       i_req_op,
   input  logic [SET_W-1:0] i_req_set,
   input  logic [WAY_W-1:0] i_req_way,
   input  logic [N_WAY-1:0] i_req_valid_mask,
   input  logic [N_WAY-1:0] i_req_lock_mask,
   output logic             o_rsp_valid,
   output logic [WAY_W-1:0] o_rsp_way,
   output logic             o_rsp_from_invalid,
   output logic             o_rsp_none,
   output logic             o_flush_busy
);

   localparam int unsigned N_NODE = N_WAY - 1;
   localparam int unsigned N_TOT  = 2 * N_WAY - 1;

   localparam logic [1:0] OP_TOUCH  = 2'd0;
   localparam logic [1:0] OP_VICTIM = 2'd1;
   localparam logic [1:0] OP_ALLOC  = 2'd2;
   localparam logic [1:0] OP_FLUSH  = 2'd3;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_FLUSH = 1'b1;

   logic [N_NODE-1:0] r_tree [N_SETS];
   logic [0:0]        r_state;
   logic [SET_W:0]    r_flush_cnt;
   logic              r_rsp_valid;
   logic [WAY_W-1:0]  r_rsp_way;
   logic              r_rsp_from_invalid;
   logic              r_rsp_none;

   logic              w_accept;
   logic              w_is_victim;
   logic              w_flush_last;
   logic [N_NODE-1:0] w_cur_tree;
   logic              w_inv_found;
   logic [WAY_W-1:0]  w_inv_way;
   logic [WAY_W-1:0]  w_walk_way;
   logic              w_vic_none;
   logic              w_vic_inv;
   logic [WAY_W-1:0]  w_vic_way;
   logic [WAY_W-1:0]  w_upd_way;
   logic [N_NODE-1:0] w_upd_tree;
   logic              w_wr_en;
   logic [SET_W-1:0]  w_wr_set;
   logic [N_NODE-1:0] w_wr_data;

   assign o_req_ready  = (r_state == S_IDLE);
   assign o_flush_busy = (r_state == S_FLUSH);
   assign w_accept     = i_req_valid & o_req_ready;
   assign w_is_victim  = w_accept & ((i_req_op == OP_VICTIM) | (i_req_op == OP_ALLOC));
   assign w_flush_last = (r_flush_cnt == (SET_W + 1)'(N_SETS - 1));
   assign w_cur_tree   = r_tree[i_req_set];

   // Lowest-index way that is both invalid and unlocked.
   always_comb begin
      w_inv_found = 1'b0;
      w_inv_way   = '0;
      for (int i = N_WAY - 1; i >= 0; i--) begin
         if (!i_req_valid_mask[i] && !i_req_lock_mask[i]) begin
            w_inv_found = 1'b1;
            w_inv_way   = WAY_W'(i);
         end
      end
   end

   // Heap-indexed full tree: nodes 0..N_NODE-1 internal, N_NODE+i is leaf (way) i.
   always_comb begin
      logic [N_TOT-1:0] v_lock;
      logic [N_TOT-1:0] v_path;
      logic             v_dir;
      v_lock = '0;
      v_path = '0;
      v_dir  = 1'b0;
      for (int i = 0; i < N_WAY; i++) begin
         v_lock[N_NODE + i] = i_req_lock_mask[i];
      end
      for (int n = N_NODE - 1; n >= 0; n--) begin
         v_lock[n] = v_lock[2*n+1] & v_lock[2*n+2];
      end
      v_path[0] = 1'b1;
      for (int n = 0; n < N_NODE; n++) begin
         v_dir = ~w_cur_tree[n];
         if (v_dir ? v_lock[2*n+2] : v_lock[2*n+1]) begin
            v_dir = ~v_dir;
         end
         v_path[2*n+1] = v_path[n] & ~v_dir;
         v_path[2*n+2] = v_path[n] & v_dir;
      end
      w_walk_way = '0;
      for (int i = 0; i < N_WAY; i++) begin
         if (v_path[N_NODE + i]) begin
            w_walk_way = WAY_W'(i);
         end
      end
      w_vic_none = v_lock[0];
   end

   assign w_vic_inv = w_inv_found & ~w_vic_none;
   assign w_vic_way = w_vic_none  ? '0 :
                      w_inv_found ? w_inv_way : w_walk_way;

   assign w_upd_way = (i_req_op == OP_TOUCH) ? i_req_way : w_vic_way;

   // Each node on the touched way's path points toward the child containing that way.
   always_comb begin
      logic [N_TOT-1:0] v_has;
      v_has = '0;
      for (int i = 0; i < N_WAY; i++) begin
         v_has[N_NODE + i] = (w_upd_way == WAY_W'(i));
      end
      for (int n = N_NODE - 1; n >= 0; n--) begin
         v_has[n] = v_has[2*n+1] | v_has[2*n+2];
      end
      w_upd_tree = w_cur_tree;
      for (int n = 0; n < N_NODE; n++) begin
         if (v_has[n]) begin
            w_upd_tree[n] = v_has[2*n+2];
         end
      end
   end

   always_comb begin
      w_wr_en   = 1'b0;
      w_wr_set  = i_req_set;
      w_wr_data = w_upd_tree;
      if (r_state == S_FLUSH) begin
         w_wr_en   = 1'b1;
         w_wr_set  = r_flush_cnt[SET_W-1:0];
         w_wr_data = '0;
      end else if (w_accept && ((i_req_op == OP_TOUCH) ||
                                ((i_req_op == OP_ALLOC) && !w_vic_none))) begin
         w_wr_en = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int s = 0; s < N_SETS; s++) begin
            r_tree[s] <= '0;
         end
      end else if (w_wr_en) begin
         r_tree[w_wr_set] <= w_wr_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_flush_cnt <= '0;
      end else if (r_state == S_IDLE) begin
         if (w_accept && (i_req_op == OP_FLUSH)) begin
            r_state     <= S_FLUSH;
            r_flush_cnt <= '0;
         end
      end else begin
         r_flush_cnt <= r_flush_cnt + (SET_W + 1)'(1);
         if (w_flush_last) begin
            r_state <= S_IDLE;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rsp_valid        <= 1'b0;
         r_rsp_way          <= '0;
         r_rsp_from_invalid <= 1'b0;
         r_rsp_none         <= 1'b0;
      end else begin
         r_rsp_valid <= w_is_victim;
         if (w_is_victim) begin
            r_rsp_way          <= w_vic_way;
            r_rsp_from_invalid <= w_vic_inv;
            r_rsp_none         <= w_vic_none;
         end
      end
   end

   assign o_rsp_valid        = r_rsp_valid;
   assign o_rsp_way          = r_rsp_way;
   assign o_rsp_from_invalid = r_rsp_from_invalid;
   assign o_rsp_none         = r_rsp_none;

endmodule

// File: doc/plru_repl_unit.md
Name: plru_repl_unit

Overview:
- Sequential tree-PLRU replacement engine for the LLC, parametrised in associativity and set count.
- Owns per-set PLRU tree storage and accepts one command per cycle: touch, victim query, or victim-and-allocate.
- Victim selection prefers invalid ways and honours a per-request way-lock mask.
- Provides a multi-cycle flush sweep; sits beside the tag array and is driven by the cache controller FSM.

Parameters:
- N_WAY, 16, associativity; power of 2, at least 2; tree holds N_WAY-1 bits per set.
- N_SETS, 64, number of sets; power of 2, at least 2.
- WAY_W, $clog2(N_WAY), way index width (derived).
- SET_W, $clog2(N_SETS), set index width (derived).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  command valid
- req_ready  out  1  unit accepts command; low during flush
- req_op  in  2  0=TOUCH, 1=VICTIM, 2=VICTIM_ALLOC, 3=FLUSH
- req_set  in  SET_W  target set (ignored for FLUSH)
- req_way  in  WAY_W  way to touch (TOUCH only)
- req_valid_mask  in  N_WAY  bit i=1: way i holds a valid (non-I) line
- req_lock_mask  in  N_WAY  bit i=1: way i may not be chosen as victim
- rsp_valid  out  1  victim response valid
- rsp_way  out  WAY_W  chosen victim way
- rsp_from_invalid  out  1  victim chosen because it was invalid
- rsp_none  out  1  every way locked; no victim available
- flush_busy  out  1  flush sweep in progress

Behaviour:
- Reset (async, rst_n low): all tree bits 0; FSM goes to IDLE; req_ready=1 after release; rsp_valid, rsp_way, rsp_from_invalid, rsp_none, flush_busy all 0.
- Accept: a command is accepted on a rising edge where req_valid && req_ready.
- Tree encoding: node 0 is the root. The children of node b are 2b+1 (way bit 0, left) and 2b+2 (way bit 1, right). Way bits are consumed MSB first.
- Update (touch way w): at each level, bit[node] = w bit; next node = 2*node+1+w bit. Exactly WAY_W bits are written; all other bits are unchanged.
- Victim, step 1: choose the lowest-index way with valid_mask=0 and lock_mask=0. If one exists, rsp_from_invalid=1.
- Victim, step 2: otherwise walk the tree from the root toward the opposite of each node bit.
  - If the preferred subtree has all ways locked, take the other subtree.
  - If all N_WAY ways are locked: rsp_none=1, rsp_way=0, and no tree update.
- Timing: storage is read combinationally in the accept cycle; the tree write commits at that same edge. The response registers on that edge, so rsp_valid is high for exactly one cycle, one cycle after accept.
- Throughput: fully pipelined, one command per cycle, no response backpressure. Back-to-back commands to the same set see the previous command's update.
- TOUCH: updates the tree only; no response.
- VICTIM: response only; no tree update.
- VICTIM_ALLOC: response, plus a touch of the chosen way in the same edge (skipped when rsp_none).
- FSM IDLE: on an accepted FLUSH, go to FLUSH and clear the set counter to 0. flush_busy=1 and req_ready=0 from the next cycle.
- FSM FLUSH: each cycle, zero the tree of set[counter] and increment the counter. After set N_SETS-1 is cleared, return to IDLE; flush lasts exactly N_SETS cycles and req_ready returns to 1 on the following cycle.
- FLUSH produces no rsp_valid. The counter is SET_W+1 bits wide so it needs no wrap.
- Reset mid-flush: immediate return to IDLE with all trees cleared; no partial state remains.
- Out-of-range req_way cannot occur (width is exact). req_set is ignored for FLUSH.

Test Plan:
- Reset victim: N_WAY=16, reset, VICTIM set 5 with valid_mask=0xFFFF, lock_mask=0 -> next cycle rsp_valid=1, rsp_way=15, rsp_from_invalid=0, rsp_none=0.
- Touch then victim: TOUCH set 5 way 15, then VICTIM set 5 (all valid, none locked) on the next cycle -> rsp_way=7; set 6 still returns 15.
- Invalid priority: valid_mask=0xFFF3, lock_mask=0x0004 -> rsp_way=3, rsp_from_invalid=1. Issue as VICTIM_ALLOC, then VICTIM (all valid) -> the second victim is not in ways 0-3; it is way 15.
- Lock steering: fresh tree, all valid, lock_mask=0x8000 -> rsp_way=14. lock_mask=0xFFFF -> rsp_none=1, rsp_way=0, tree unchanged (next unlocked VICTIM returns 15).
- Flush: touch sets 0 and 63, FLUSH -> req_ready=0 and flush_busy=1 for exactly 64 cycles, no rsp_valid. Afterwards VICTIM on sets 0 and 63 -> 15.
- Reset mid-flush: assert rst_n=0 at flush cycle 20 -> flush_busy=0 and req_ready=1 after release; every set returns victim 15.
